setup_move_sequencer: RTL

- Responder to the cube-state scanner's observation handshake.
- On each `send_setup_moves` request it looks up the move list for the current observation index and drives the motor driver one move at a time, using a valid/ack handshake plus a done pulse per move.
- After the last move it waits out a mechanical settle time, then asserts `color_sensor_stable`.
- Sits between the state-determination FSM and the per-face motor driver.

---
 rtl/setup_move_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/setup_move_sequencer.sv
// setup_move_sequencer
// Answers the scanner's observation handshake. For each accepted request it
// plays the setup move list for observation index k to the motor driver, one
// move at a time (valid/ack, then a done pulse). After the last move it waits
// out the mechanical settle time and then reports color_sensor_stable.
// Optional build macro: MOVE_TIMEOUT_EN adds a per-move watchdog on motor_done.
module setup_move_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 32'd1000000,
`ifdef MOVE_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000,
`endif
  parameter int unsigned LAST_INDEX     = 32'd48
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send_setup_moves,
  input  logic [5:0] counter,
  input  logic       move_ack,
  input  logic       motor_done,
  output logic [2:0] move_face,
  output logic [1:0] move_dir,
  output logic       move_valid,
  output logic       color_sensor_stable,
  output logic       busy,
  output logic       error
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_STABLE    = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  localparam logic [5:0]  LAST_K      = 6'(LAST_INDEX);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 32'd1);
`ifdef MOVE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);
`endif

  // Move encoding {face[2:0], dir[1:0]}; faces U0 L1 F2 R3 B4 D5, dirs CW0 CCW1 half2
  localparam logic [4:0] MV_NONE = 5'd0;
  localparam logic [4:0] U_CW    = {3'd0, 2'd0};
  localparam logic [4:0] U_CCW   = {3'd0, 2'd1};
  localparam logic [4:0] L_CW    = {3'd1, 2'd0};
  localparam logic [4:0] L_CCW   = {3'd1, 2'd1};
  localparam logic [4:0] L_2     = {3'd1, 2'd2};
  localparam logic [4:0] F_CW    = {3'd2, 2'd0};
  localparam logic [4:0] F_CCW   = {3'd2, 2'd1};
  localparam logic [4:0] F_2     = {3'd2, 2'd2};
  localparam logic [4:0] R_CW    = {3'd3, 2'd0};
  localparam logic [4:0] R_CCW   = {3'd3, 2'd1};
  localparam logic [4:0] R_2     = {3'd3, 2'd2};
  localparam logic [4:0] B_CW    = {3'd4, 2'd0};
  localparam logic [4:0] B_CCW   = {3'd4, 2'd1};
  localparam logic [4:0] B_2     = {3'd4, 2'd2};

  // Batch ROM row: {length[3:0], move0, move1, ..., move5}; undo selects the inverse list
  function automatic logic [33:0] rom_row(input logic undo, input logic [3:0] batch);
    logic [33:0] row;
    row = 34'd0;
    case ({undo, batch})
      5'd1:    row = {4'd2, F_CW,  B_CCW, MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd2:    row = {4'd2, L_CCW, R_CW,  MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd3:    row = {4'd2, F_CCW, B_CW,  MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd4:    row = {4'd2, L_CW,  R_CCW, MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd5:    row = {4'd2, L_2,   R_2,   MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd7:    row = {4'd6, F_CW,  B_CCW, L_CW,  U_CW,  F_CW,  B_CCW};
      5'd8:    row = {4'd6, L_CCW, R_CW,  F_CW,  U_CCW, L_CCW, R_CW};
      5'd9:    row = {4'd6, F_CCW, B_CW,  R_CW,  U_CW,  F_CCW, B_CW};
      5'd10:   row = {4'd6, L_CW,  R_CCW, B_CCW, U_CW,  L_CW,  R_CCW};
      5'd11:   row = {4'd4, R_2,   L_2,   F_2,   B_2,   MV_NONE, MV_NONE};
      5'd17:   row = {4'd2, B_CW,  F_CCW, MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd18:   row = {4'd2, R_CCW, L_CW,  MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd19:   row = {4'd2, B_CCW, F_CW,  MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd20:   row = {4'd2, R_CW,  L_CCW, MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd21:   row = {4'd2, L_2,   R_2,   MV_NONE, MV_NONE, MV_NONE, MV_NONE};
      5'd23:   row = {4'd6, B_CW,  F_CCW, U_CCW, L_CCW, B_CW,  F_CCW};
      5'd24:   row = {4'd6, R_CCW, L_CW,  U_CW,  F_CCW, R_CCW, L_CW};
      5'd25:   row = {4'd6, B_CCW, F_CW,  U_CCW, R_CCW, B_CCW, F_CW};
      5'd26:   row = {4'd6, R_CW,  L_CCW, U_CCW, B_CW,  R_CW,  L_CCW};
      5'd27:   row = {4'd4, B_2,   F_2,   L_2,   R_2,   MV_NONE, MV_NONE};
      default: row = 34'd0;
    endcase
    return row;
  endfunction

  // Pick move idx out of a six-move row body
  function automatic logic [4:0] pick_move(input logic [29:0] moves, input logic [3:0] idx);
    logic [4:0] mv;
    mv = 5'd0;
    case (idx)
      4'd0:    mv = moves[29:25];
      4'd1:    mv = moves[24:20];
      4'd2:    mv = moves[19:15];
      4'd3:    mv = moves[14:10];
      4'd4:    mv = moves[9:5];
      4'd5:    mv = moves[4:0];
      default: mv = 5'd0;
    endcase
    return mv;
  endfunction

  state_t      state_r, state_s;
  logic [5:0]  k_r, k_s;
  logic [1:0]  part_r, part_s;
  logic [3:0]  ptr_r, ptr_s;
  logic [31:0] settle_r, settle_s;
  logic [2:0]  face_r, face_s;
  logic [1:0]  dir_r, dir_s;
  logic        valid_r, valid_s;
  logic        busy_r, busy_s;
  logic        stable_r, stable_s;
  logic        error_r, error_s;
`ifdef MOVE_TIMEOUT_EN
  logic [31:0] wdog_r, wdog_s;
`endif

  logic [33:0] undo_row_s, setup_row_s;
  logic [3:0]  len0_s, len1_s, len2_s, cur_len_s;
  logic [29:0] cur_moves_s;
  logic [4:0]  cur_move_s;
  logic        has_more_s;

  // Move-list view of the latched request: part lengths, current move, moves left
  always_comb begin
    undo_row_s  = rom_row(1'b1, k_r[5:2] - 4'd1);
    setup_row_s = rom_row(1'b0, k_r[5:2]);
    len0_s = (k_r != 6'd0) ? 4'd1 : 4'd0;
    len1_s = ((k_r != 6'd0) && (k_r[1:0] == 2'd0)) ? undo_row_s[33:30] : 4'd0;
    len2_s = ((k_r[1:0] == 2'd0) && (k_r < LAST_K)) ? setup_row_s[33:30] : 4'd0;
    cur_len_s   = 4'd0;
    cur_moves_s = 30'd0;
    case (part_r)
      2'd0: begin
        cur_len_s   = len0_s;
        cur_moves_s = {U_CW, 25'd0};
      end
      2'd1: begin
        cur_len_s   = len1_s;
        cur_moves_s = undo_row_s[29:0];
      end
      2'd2: begin
        cur_len_s   = len2_s;
        cur_moves_s = setup_row_s[29:0];
      end
      default: begin
        cur_len_s   = 4'd0;
        cur_moves_s = 30'd0;
      end
    endcase
    cur_move_s = pick_move(cur_moves_s, ptr_r);
    has_more_s = (({1'b0, ptr_r} + 5'd1) < {1'b0, cur_len_s})
               || ((part_r == 2'd0) && ((len1_s != 4'd0) || (len2_s != 4'd0)))
               || ((part_r == 2'd1) && (len2_s != 4'd0));
  end

  // Next-state and next-register values for the sequencer FSM
  always_comb begin
    state_s  = state_r;
    k_s      = k_r;
    part_s   = part_r;
    ptr_s    = ptr_r;
    settle_s = settle_r;
    face_s   = face_r;
    dir_s    = dir_r;
    valid_s  = valid_r;
    busy_s   = busy_r;
    stable_s = stable_r;
    error_s  = error_r;
`ifdef MOVE_TIMEOUT_EN
    wdog_s   = wdog_r;
`endif
    case (state_r)
      ST_IDLE, ST_STABLE: begin
        if (send_setup_moves) begin
          if (counter > LAST_K) begin
            state_s  = ST_ERROR;
            error_s  = 1'b1;
            busy_s   = 1'b0;
            stable_s = 1'b0;
            valid_s  = 1'b0;
          end else begin
            k_s      = counter;
            busy_s   = 1'b1;
            stable_s = 1'b0;
            part_s   = 2'd0;
            ptr_s    = 4'd0;
            settle_s = 32'd0;
            // index 0 has no moves at all: straight to the settle wait
            state_s  = (counter == 6'd0) ? ST_SETTLE : ST_LOAD;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (part_r == 2'd3) begin
          settle_s = 32'd0;
          state_s  = ST_SETTLE;
        end else if (ptr_r < cur_len_s) begin
          face_s  = cur_move_s[4:2];
          dir_s   = cur_move_s[1:0];
          valid_s = 1'b1;
          state_s = ST_ISSUE;
        end else begin
          // current part exhausted or empty: step to the next part
          part_s = part_r + 2'd1;
          ptr_s  = 4'd0;
        end
      end
      ST_ISSUE: begin
        if (move_ack) begin
          valid_s = 1'b0;
          state_s = ST_WAIT_DONE;
`ifdef MOVE_TIMEOUT_EN
          wdog_s  = 32'd0;
`endif
        end else begin
          valid_s = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (motor_done) begin
          if (has_more_s) begin
            ptr_s   = ptr_r + 4'd1;
            state_s = ST_LOAD;
          end else begin
            settle_s = 32'd0;
            state_s  = ST_SETTLE;
          end
        end else begin
`ifdef MOVE_TIMEOUT_EN
          if (wdog_r == TIMEOUT_LAST) begin
            state_s  = ST_ERROR;
            error_s  = 1'b1;
            busy_s   = 1'b0;
            stable_s = 1'b0;
            valid_s  = 1'b0;
          end else begin
            wdog_s = wdog_r + 32'd1;
          end
`else
          state_s = ST_WAIT_DONE;
`endif
        end
      end
      ST_SETTLE: begin
        if (settle_r == SETTLE_LAST) begin
          stable_s = 1'b1;
          busy_s   = 1'b0;
          state_s  = ST_STABLE;
        end else begin
          settle_s = settle_r + 32'd1;
        end
      end
      ST_ERROR: begin
        error_s  = 1'b1;
        busy_s   = 1'b0;
        stable_s = 1'b0;
        valid_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any sequence in flight
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      k_r      <= 6'd0;
      part_r   <= 2'd0;
      ptr_r    <= 4'd0;
      settle_r <= 32'd0;
      face_r   <= 3'd0;
      dir_r    <= 2'd0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      stable_r <= 1'b0;
      error_r  <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      wdog_r   <= 32'd0;
`endif
    end else begin
      state_r  <= state_s;
      k_r      <= k_s;
      part_r   <= part_s;
      ptr_r    <= ptr_s;
      settle_r <= settle_s;
      face_r   <= face_s;
      dir_r    <= dir_s;
      valid_r  <= valid_s;
      busy_r   <= busy_s;
      stable_r <= stable_s;
      error_r  <= error_s;
`ifdef MOVE_TIMEOUT_EN
      wdog_r   <= wdog_s;
`endif
    end
  end

  assign move_face  = face_r;
  assign move_dir   = dir_r;
  assign move_valid = valid_r;
  assign busy       = busy_r;
  assign error      = error_r;
  // masking with the request keeps a stale stable from being seen as a request goes up
  assign color_sensor_stable = stable_r & ~send_setup_moves;

endmodule
